// File: rtl/vector_mem_sequencer_if.sv
// Memory-side bus of the vector sequencer: two byte-wide sync-RAM ports (A/B).
// master: the sequencer drives addresses, write data and enables, and receives read data.
// slave : the data memory consumes the requests and returns read data one cycle after re.
interface vector_mem_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_addr_a;
    logic [ADDR_W-1:0] mem_addr_b;
    logic [7:0]        mem_wdata_a;
    logic [7:0]        mem_wdata_b;
    logic              mem_we_a;
    logic              mem_we_b;
    logic              mem_re_a;
    logic              mem_re_b;
    logic [7:0]        mem_rdata_a;
    logic [7:0]        mem_rdata_b;

    modport master (
        output mem_addr_a, mem_addr_b, mem_wdata_a, mem_wdata_b,
        output mem_we_a, mem_we_b, mem_re_a, mem_re_b,
        input  mem_rdata_a, mem_rdata_b
    );

    modport slave (
        input  mem_addr_a, mem_addr_b, mem_wdata_a, mem_wdata_b,
        input  mem_we_a, mem_we_b, mem_re_a, mem_re_b,
        output mem_rdata_a, mem_rdata_b
    );
endinterface

// File: rtl/vector_mem_sequencer.sv
// Splits one vector load/store into LANES/2 two-byte beats over the dual-port data memory.
// Latency: store done at T+LANES/2+1, load done at T+LANES/2+2 (request seen at T).
// Backpressure: stall is raised combinationally in the request cycle and held until DONE.
// Ports: clk/reset (async, active-high); req_store/req_load/base_addr/store_data from the
// memory stage; stall/done/busy/load_data back to the pipeline; mem = memory bus (master).
// Optional macro VSEQ_PERF_COUNTER_EN adds perf_busy_cycles/perf_ops saturating counters.
module vector_mem_sequencer #(
    parameter int ADDR_W = 16,
    parameter int LANES  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_store,
    input  logic                 req_load,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [8*LANES-1:0]   store_data,
    output logic                 stall,
    output logic                 done,
    output logic                 busy,
    output logic [8*LANES-1:0]   load_data,
    vector_mem_sequencer_if.master mem
`ifdef VSEQ_PERF_COUNTER_EN
    ,
    output logic [15:0]          perf_busy_cycles,
    output logic [15:0]          perf_ops
`endif
);

    localparam int BEATS = LANES / 2;
    localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STORE,
        S_LOAD,
        S_LOAD_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [KW-1:0]      beat;
    logic [KW-1:0]      beat_nxt;
    logic [KW-1:0]      cap_idx;
    logic               last_beat;
    logic [ADDR_W-1:0]  base_q;
    logic [8*LANES-1:0] data_q;
    logic [8*LANES-1:0] asm_q;
    logic [8*LANES-1:0] asm_merged;
    logic [ADDR_W-1:0]  addr_nxt;

    logic [ADDR_W-1:0]  addr_a_q, addr_b_q;
    logic [7:0]         wdata_a_q, wdata_b_q;
    logic               we_a_q, we_b_q, re_a_q, re_b_q;

    assign last_beat = (beat == KW'(BEATS - 1));
    assign beat_nxt  = beat + KW'(1);
    assign addr_nxt  = base_q + ADDR_W'({beat_nxt, 1'b0});

    // Read data arriving now belongs to the beat issued one cycle earlier; in the drain
    // cycle the counter was left on the last beat, so no adjustment is needed there.
    assign cap_idx = (state == S_LOAD_DRAIN) ? beat : (beat - KW'(1));

    always_comb begin
        asm_merged = asm_q;
        asm_merged[{cap_idx, 4'd0} +: 16] = {mem.mem_rdata_b, mem.mem_rdata_a};
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        done      = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (req_store) begin
                    state_nxt = S_STORE;
                    stall     = 1'b1;
                end else if (req_load) begin
                    state_nxt = S_LOAD;
                    stall     = 1'b1;
                end
            end
            S_STORE: begin
                stall = 1'b1;
                if (last_beat) state_nxt = S_DONE;
            end
            S_LOAD: begin
                stall = 1'b1;
                if (last_beat) state_nxt = S_LOAD_DRAIN;
            end
            S_LOAD_DRAIN: begin
                stall     = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    // Memory outputs are registered: beat k is presented during the k-th cycle after the
    // request, so beat 0 is issued straight from the live request inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat      <= '0;
            base_q    <= '0;
            data_q    <= '0;
            asm_q     <= '0;
            load_data <= '0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            wdata_a_q <= '0;
            wdata_b_q <= '0;
            we_a_q    <= 1'b0;
            we_b_q    <= 1'b0;
            re_a_q    <= 1'b0;
            re_b_q    <= 1'b0;
        end else begin
            we_a_q <= 1'b0;
            we_b_q <= 1'b0;
            re_a_q <= 1'b0;
            re_b_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_store || req_load) begin
                        base_q   <= base_addr;
                        beat     <= '0;
                        addr_a_q <= base_addr;
                        addr_b_q <= base_addr + ADDR_W'(1);
                        if (req_store) begin
                            data_q    <= store_data;
                            wdata_a_q <= store_data[7:0];
                            wdata_b_q <= store_data[15:8];
                            we_a_q    <= 1'b1;
                            we_b_q    <= 1'b1;
                        end else begin
                            re_a_q <= 1'b1;
                            re_b_q <= 1'b1;
                        end
                    end
                end
                S_STORE: begin
                    if (!last_beat) begin
                        beat      <= beat_nxt;
                        addr_a_q  <= addr_nxt;
                        addr_b_q  <= addr_nxt + ADDR_W'(1);
                        wdata_a_q <= data_q[{beat_nxt, 4'd0} +: 8];
                        wdata_b_q <= data_q[{beat_nxt, 4'd0} + 8 +: 8];
                        we_a_q    <= 1'b1;
                        we_b_q    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (beat != '0) asm_q <= asm_merged;
                    if (!last_beat) begin
                        beat     <= beat_nxt;
                        addr_a_q <= addr_nxt;
                        addr_b_q <= addr_nxt + ADDR_W'(1);
                        re_a_q   <= 1'b1;
                        re_b_q   <= 1'b1;
                    end
                end
                S_LOAD_DRAIN: begin
                    asm_q     <= asm_merged;
                    load_data <= asm_merged;
                end
                S_DONE: beat <= '0;
                default: ;
            endcase
        end
    end

    assign mem.mem_addr_a  = addr_a_q;
    assign mem.mem_addr_b  = addr_b_q;
    assign mem.mem_wdata_a = wdata_a_q;
    assign mem.mem_wdata_b = wdata_b_q;
    assign mem.mem_we_a    = we_a_q;
    assign mem.mem_we_b    = we_b_q;
    assign mem.mem_re_a    = re_a_q;
    assign mem.mem_re_b    = re_b_q;

`ifdef VSEQ_PERF_COUNTER_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_busy_cycles <= '0;
            perf_ops         <= '0;
        end else begin
            if (stall && (perf_busy_cycles != 16'hFFFF)) perf_busy_cycles <= perf_busy_cycles + 16'd1;
            if (done && (perf_ops != 16'hFFFF))          perf_ops         <= perf_ops + 16'd1;
        end
    end
`endif

endmodule

// File: doc/vector_mem_sequencer.md
Name: vector_mem_sequencer

Overview:
- Multi-cycle controller for 128-bit vector loads/stores issued from the memory stage.
- Splits one vector access into byte beats over the dual-port (A/B) data memory, 2 bytes per cycle.
- Stalls the pipeline until the access completes.
- Scalar accesses bypass this block; it only owns the memory ports while busy.

Parameters:
- ADDR_W, 16, byte address width; addresses wrap modulo 2^ADDR_W.
- LANES, 16, bytes per vector; must be even; beats = LANES/2.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- req_store  input  1  vector store request, level, from memory stage
- req_load  input  1  vector load request, level, from memory stage
- base_addr  input  ADDR_W  vector base byte address (ALU result)
- store_data  input  8*LANES  vector to store; lane i = bits [8i+7:8i]
- stall  output  1  freeze pipeline (combinational)
- done  output  1  one-cycle completion pulse
- busy  output  1  state != IDLE
- load_data  output  8*LANES  assembled load result, held until next load completes
- mem_addr_a, mem_addr_b  output  ADDR_W  port addresses
- mem_wdata_a, mem_wdata_b  output  8  write bytes
- mem_we_a, mem_we_b  output  1  write enables
- mem_re_a, mem_re_b  output  1  read enables
- mem_rdata_a, mem_rdata_b  input  8  read data, valid 1 cycle after re (sync RAM)

Behaviour:
- Reset (async): state=IDLE; all outputs 0, including load_data; beat counter 0.
- States: IDLE, STORE, LOAD, LOAD_DRAIN, DONE.
- IDLE, req_store=1:
  - Latch base_addr and store_data.
  - Go to STORE, beat k=0.
  - stall=1 combinationally in the request cycle.
- IDLE, req_load=1 (and req_store=0): latch base_addr, go to LOAD, k=0, stall=1.
- Both requests high: store wins; the load is not performed.
- STORE beat k (0..LANES/2-1), registered outputs:
  - mem_we_a=1, mem_addr_a=base+2k, mem_wdata_a=lane 2k.
  - mem_we_b=1, mem_addr_b=base+2k+1, mem_wdata_b=lane 2k+1.
  - After last beat go to DONE.
- LOAD beat k: mem_re_a/b=1, same addresses as STORE.
  - Data returned in the following cycle is written into lanes 2k / 2k+1 of the assembly register.
  - After last issue go to LOAD_DRAIN: capture final pair, no re; then go to DONE.
- DONE:
  - done=1 and stall=0 for exactly one cycle.
  - For loads, load_data is updated to the assembled vector on the cycle done rises.
  - Requests are ignored; next state is IDLE.
- stall = (state != IDLE && state != DONE) || (state == IDLE && (req_store || req_load)).
- Latency, request seen at cycle T, LANES=16:
  - Store: writes at T+1..T+8, done at T+9.
  - Load: reads issued T+1..T+8, data at T+2..T+9, done at T+10.
- Address arithmetic: ADDR_W-bit add, carry discarded. base=0xFFFF, lane 1 goes to address 0x0000.
- Outside STORE/LOAD: we/re = 0; addr/wdata hold their last values.
- Request changes after latching have no effect on an op in progress.
- Reset mid-operation:
  - Immediate abort; we/re drop asynchronously.
  - No done pulse; load_data keeps its reset value of 0.
- base_addr and store_data do not need to stay stable after the request cycle.

Optional Feature:
- Macro VSEQ_PERF_COUNTER_EN.
- When defined:
  - Adds output perf_busy_cycles [15:0]: counts cycles with stall=1, saturating at 0xFFFF.
  - Adds output perf_ops [15:0]: counts done pulses, saturating at 0xFFFF.
  - Both are cleared by reset.
- When undefined: neither port nor any counter logic exists; all other behaviour is identical.

Test Plan:
- Store, base=0x0100, store_data=0x0F0E..0100 (lane i=i):
  - stall high T..T+8.
  - Beat k writes A=(0x0100+2k, 2k) and B=(0x0101+2k, 2k+1).
  - done at T+9 only; exactly 16 byte writes in total.
- Load, base=0x0200, memory[0x0200+i]=0xA0+i:
  - 8 read beats, done at T+10.
  - load_data=0xAFAE..A1A0; stall low in the done cycle.
- Wrap: store at base=0xFFFE, lane i=0x10+i:
  - Beat 0 writes 0xFFFE/0xFFFF; beat 1 writes 0x0000/0x0001; done at T+9.
- Simultaneous req_store=req_load=1 at base=0x0300: only the store sequence occurs, no re, single done.
- Reset asserted at load beat 4:
  - Outputs go to 0 immediately; no done pulse; load_data=0.
  - A new load after reset completes normally.
- Back-to-back: store then load requested the cycle after done:
  - Load is accepted in the IDLE cycle.
  - With VSEQ_PERF_COUNTER_EN: perf_ops=2, perf_busy_cycles=19.
